// File: rtl/core_mem_pkg.sv
// Shared types and constants for the core-to-memory request arbiter.
package core_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    localparam int unsigned COP_READ  = 0;
    localparam int unsigned SIZE_WORD = 4;

    // On a tie the port that did not win last time takes the bus.
    function automatic grant_t rr_choose(input logic i_val, input logic d_val, input grant_t last);
        if (i_val && d_val)
            return (last == GNT_I) ? GNT_D : GNT_I;
        else if (d_val)
            return GNT_D;
        else
            return GNT_I;
    endfunction

endpackage

// File: rtl/core_mem_rr_pick.sv
// Two-way round-robin selector; last_grant doubles as the owner of the in-flight request.
module core_mem_rr_pick
    import core_mem_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_val,
    input  logic   d_val,
    input  logic   take,
    output grant_t grant,
    output grant_t last_grant
);

    always_comb begin
        grant = rr_choose(i_val, d_val, last_grant);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            last_grant <= GNT_I;
        else if (take)
            last_grant <= grant;
    end

endmodule

// File: rtl/core_mem_arb.sv
// Merges the instruction and data request ports onto one registered memory request bus
// and steers the memory completion back to the requester as a one-cycle ack.
module core_mem_arb
    import core_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int COP_W  = 3,
    parameter int SIZE_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_val,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_req_ack,
    output logic [DATA_W-1:0] i_ack_rdata,
    input  logic              d_req_val,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [COP_W-1:0]  d_req_cop,
    input  logic [DATA_W-1:0] d_req_wdata,
    input  logic [SIZE_W-1:0] d_req_size,
    output logic              d_req_ack,
    output logic [DATA_W-1:0] d_ack_rdata,
    output logic              m_req_val,
    output logic [ADDR_W-1:0] m_req_addr,
    output logic [COP_W-1:0]  m_req_cop,
    output logic [DATA_W-1:0] m_req_wdata,
    output logic [SIZE_W-1:0] m_req_size,
    input  logic              m_req_ack,
    input  logic [DATA_W-1:0] m_ack_rdata
);

    state_t state;
    grant_t grant;
    grant_t last_grant;
    logic   take;

    assign take = (state == IDLE) && (i_req_val || d_req_val);

    core_mem_rr_pick u_pick (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_val      (i_req_val),
        .d_val      (d_req_val),
        .take       (take),
        .grant      (grant),
        .last_grant (last_grant)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            m_req_val   <= 1'b0;
            m_req_addr  <= '0;
            m_req_cop   <= '0;
            m_req_wdata <= '0;
            m_req_size  <= '0;
            i_req_ack   <= 1'b0;
            d_req_ack   <= 1'b0;
            i_ack_rdata <= '0;
            d_ack_rdata <= '0;
        end else begin
            i_req_ack <= 1'b0;
            d_req_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        m_req_val <= 1'b1;
                        state     <= WAIT;
                        if (grant == GNT_D) begin
                            m_req_addr  <= d_req_addr;
                            m_req_cop   <= d_req_cop;
                            m_req_wdata <= d_req_wdata;
                            m_req_size  <= d_req_size;
                        end else begin
                            m_req_addr  <= i_req_addr;
                            m_req_cop   <= COP_W'(COP_READ);
                            m_req_wdata <= '0;
                            m_req_size  <= SIZE_W'(SIZE_WORD);
                        end
                    end
                end
                WAIT: begin
                    // last_grant was updated at grant time, so it names the owner here.
                    if (m_req_ack) begin
                        m_req_val <= 1'b0;
                        state     <= RESP;
                        if (last_grant == GNT_D) begin
                            d_ack_rdata <= m_ack_rdata;
                            d_req_ack   <= 1'b1;
                        end else begin
                            i_ack_rdata <= m_ack_rdata;
                            i_req_ack   <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/core_mem_arb.md
Name: core_mem_arb

Overview:
- Sits directly downstream of core_top's instruction and data request ports.
- Merges the two ports onto a single shared memory request bus using round-robin arbitration.
- Captures each granted request and holds it stable until memory acknowledges.
- Returns the read data to the originating port as a one-cycle ack pulse.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, read/write data width
- COP_W, 3, command opcode width
- SIZE_W, 3, access size width, in bytes

Ports:
- clk  input  1  core clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- i_req_val  input  1  instruction fetch request valid
- i_req_addr  input  ADDR_W  fetch address
- i_req_ack  output  1  fetch complete pulse
- i_ack_rdata  output  DATA_W  fetch data, valid when i_req_ack=1
- d_req_val  input  1  data request valid
- d_req_addr  input  ADDR_W  data address
- d_req_cop  input  COP_W  data opcode
- d_req_wdata  input  DATA_W  store data
- d_req_size  input  SIZE_W  access size
- d_req_ack  output  1  data complete pulse
- d_ack_rdata  output  DATA_W  load data, valid when d_req_ack=1
- m_req_val  output  1  memory request valid
- m_req_addr  output  ADDR_W  memory address
- m_req_cop  output  COP_W  memory opcode
- m_req_wdata  output  DATA_W  memory write data
- m_req_size  output  SIZE_W  memory access size
- m_req_ack  input  1  memory completion pulse
- m_ack_rdata  input  DATA_W  memory read data, valid with m_req_ack

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; last_grant=I.
  - All outputs 0: m_req_val, m_req_addr/cop/wdata/size, i_req_ack, d_req_ack, i_ack_rdata, d_ack_rdata.
  - Reset mid-transaction abandons the transaction silently; no ack is issued.
- Handshake, core side:
  - Requester holds val and fields until it sees ack.
  - Ack is a single-cycle pulse; rdata is valid only in that cycle.
- Handshake, memory side:
  - m_req_val and all fields are registered and held constant until the cycle m_req_ack=1.
- FSM IDLE:
  - No val: stay in IDLE.
  - One val: grant that port.
  - Both vals: grant the port opposite last_grant. After reset D wins the first tie.
  - On grant: capture the fields into m_req_* registers, set m_req_val=1, update last_grant, go to WAIT.
  - I grants drive cop=COP_READ and size=SIZE_WORD (4).
- FSM WAIT:
  - m_req_val=1.
  - On m_req_ack=1:
    - register m_ack_rdata into the granted port's ack_rdata;
    - pulse that port's req_ack next cycle;
    - clear m_req_val next cycle;
    - go to RESP.
  - m_req_ack in the same cycle m_req_val rises is legal.
- FSM RESP:
  - Ack pulse is high for exactly this cycle; go to IDLE.
  - Requester vals are ignored in RESP (the acked request is still visible).
- Minimum latency: val sampled at cycle T → m_req_val at T+1 → ack at T+1 → core ack at T+2 → next grant sampled at T+3.
- A requester dropping val while granted is a protocol violation: the captured transaction still completes and its ack still pulses.
- m_req_ack seen in IDLE or RESP is ignored.
- ack_rdata retains its last value between pulses (not cleared).
- i_req_ack and d_req_ack are never high in the same cycle.

Decomposition:
- Package core_mem_pkg:
  - state typedef enum {IDLE, WAIT, RESP};
  - grant typedef {GNT_I, GNT_D};
  - COP_READ=3'b000; SIZE_WORD=4.
- One natural sub-module: core_mem_rr_pick (combinational 2-way round-robin selector plus last_grant register).

Test Plan:
- Reset then lone fetch:
  - Stimulus: i_req_val=1, addr 0x100; memory acks 2 cycles after m_req_val with rdata 0x00000013.
  - Required: m_req_addr=0x100, cop=0, size=4; i_req_ack pulses once with i_ack_rdata=0x00000013; d_req_ack stays 0.
- Lone store:
  - Stimulus: d addr 0x2000, cop=3'b001, wdata 0xDEADBEEF, size 4.
  - Required: m_req_* match exactly and stay stable every WAIT cycle; d_req_ack pulses once.
- Simultaneous I (0x0) and D (0x40) requests after reset:
  - Required: D served first, then I. Repeat the tie: I served first (alternation).
- Zero-wait memory (m_req_ack in first m_req_val cycle):
  - Required: core ack appears exactly 2 cycles after val sampled; no duplicate ack.
- rst_n=0 during WAIT:
  - Required: next cycle m_req_val=0, no ack pulse; the following request (addr 0x80) completes normally with D tie priority.
- Spurious m_req_ack in IDLE:
  - Required: no i_req_ack or d_req_ack; state remains IDLE.
